rom_sequencer: RTL and testbench
================================

# rom_sequencer

Address generator and data capture stage that sits directly upstream of a 16x8 ROM and downstream of the button debouncer. It drives the ROM address and captures the ROM word once the ROM's one-cycle read latency has elapsed. The address advances either on a debounced push-button edge (manual step) or on a free-running prescaled tick (auto-run). The captured word is held on a stable output for the LEDs, and the sequence halts when a configurable terminator byte is read.

## Interface
Parameters:
- AW, 4, address width; the sequence covers 0 .. 2^AW-1.
- DW, 8, ROM data width.
- PRESC, 22, auto-run tick period of 2^PRESC clk cycles.
- HALT_CODE, 8'hFF, byte value that stops the sequence.
- HALT_EN, 1, 1 enables halt-on-HALT_CODE; 0 makes HALT_CODE an ordinary byte.

Ports:
- clk  in  1  system clock (sysclk domain); all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- step  in  1  debounced button level, active high, synchronous to clk.
- run  in  1  level; 1 selects auto-run mode.
- restart  in  1  single-cycle pulse; returns the sequence to address 0.
- rom_data  in  DW  ROM output, valid one clk cycle after addr changes.
- addr  out  AW  ROM address.
- dout  out  DW  last captured ROM word.
- dout_valid  out  1  dout holds a word captured since reset.
- busy  out  1  a fetch is in progress (WAIT or CAP state).
- halted  out  1  sequence is stopped on HALT_CODE.
- wrap  out  1  one-cycle pulse when addr rolls over from 2^AW-1 to 0.

## Operation
FSM states are WAIT, CAP, SHOW and HALT.
- Reset: the FSM enters WAIT. addr=0, dout=0, dout_valid=0, busy=1, halted=0, wrap=0, step_q=0, prescaler=0. The first word is fetched automatically.
- WAIT: lasts one cycle to cover ROM latency, then goes to CAP.
- CAP:
  - dout<=rom_data and dout_valid<=1.
  - If HALT_EN and rom_data==HALT_CODE, go to HALT; otherwise go to SHOW.
- SHOW: waits for an advance event, then does addr<=addr+1 (modulo 2^AW) and goes to WAIT.
  - An advance event is a step rising edge (step & ~step_q) or an auto tick.
  - A step edge and a tick in the same cycle produce a single increment.
  - If addr==2^AW-1 when the increment happens, wrap=1 for that one cycle.
- HALT: step edges and ticks are ignored, and halted=1. Only restart or reset leaves HALT.
- restart: has priority in every state. addr<=0, prescaler<=0, next state WAIT, halted<=0. dout and dout_valid keep their values. restart is not treated as an advance event, so wrap stays 0.
- Step edges arriving in WAIT or CAP are dropped, not queued. step_q still updates every cycle.
- Prescaler:
  - Counts only while run=1 and state==SHOW; otherwise it is cleared to 0.
  - The tick fires in the cycle where count==2^PRESC-1.
  - After an advance it restarts from 0.
- Manual step edges are honoured in both modes.

## Timing
- Advance event sampled at edge E0: addr is new after E0, and busy=1 from E0.
- ROM returns the word at E1. dout updates at E2, so dout latency is 2 cycles from the event edge. busy=0 after E2.
- Auto-run period: 2^PRESC cycles in SHOW plus 2 fetch cycles, i.e. 2^PRESC+2 edges between successive addr changes.
- Minimum spacing between honoured step edges is 3 cycles. Faster edges fall in WAIT/CAP and are dropped.
- wrap is asserted in the same cycle as the first addr==0 after the rollover.
- halted is asserted after E2 of the fetch that read HALT_CODE.
- Reset asserted mid-fetch returns everything to reset values asynchronously. After deassertion the first capture happens on the 2nd rising edge.
- All outputs are registered.

## Structure
- Package rom_seq_pkg holds:
  - the state enum (WAIT=2'd0, CAP=2'd1, SHOW=2'd2, HALT=2'd3);
  - default HALT_CODE and PRESC constants.
- Sub-module tick_gen (parameter N) holds the prescaler counter with a clear input and a one-cycle tick output.
- Step edge detection and the FSM live in rom_sequencer.

## Test plan
- Reset, with ROM model contents 0x01..0x0F,0x00 and HALT_EN=0 → after 2 edges addr=0, dout=0x01, dout_valid=1, busy=0.
- Sixteen step pulses spaced 10 cycles apart → addr walks 1..15,0; dout follows the ROM contents 2 cycles after each edge; wrap pulses exactly once, on the 16th step.
- run=1, PRESC=3 → addr changes every 10 cycles. Asserting a step in the same cycle as a tick advances addr by 1, not 2.
- ROM word 0xFF at address 5, HALT_EN=1 → halted=1 and dout=0xFF. Further step edges and ticks leave addr=5. A restart pulse gives addr=0, halted=0, and dout=ROM[0] 2 cycles later.
- Step edges 1 cycle apart → only the first is honoured; addr increments once.
- rst asserted low while in WAIT → outputs go to reset values immediately without a clock. After release, dout=ROM[0] on the 2nd edge.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// rtl/rom_seq_pkg.sv - shared state encoding and default constants for the ROM sequencer
package rom_seq_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    CAP  = 2'd1,
    SHOW = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int unsigned PRESC_DEF     = 22;
  localparam logic [7:0]  HALT_CODE_DEF = 8'hFF;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running 2^N prescaler with clear, one-cycle tick at terminal count
module tick_gen #(
  parameter int unsigned N = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [N-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else begin
      count <= count + N'(1);
    end
  end

  // Gated by en so a stale count never fires once counting is disabled.
  assign tick = en && (count == '1);

endmodule

// File: rtl/rom_sequencer.sv
// rtl/rom_sequencer.sv - ROM address stepper with manual/auto advance, word capture and halt code
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int unsigned    AW        = 4,
  parameter int unsigned    DW        = 8,
  parameter int unsigned    PRESC     = PRESC_DEF,
  parameter logic [DW-1:0]  HALT_CODE = DW'(HALT_CODE_DEF),
  parameter bit             HALT_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          run,
  input  logic          restart,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          halted,
  output logic          wrap
);

  state_t        state, state_next;
  logic          step_q;
  logic          step_edge, tick, adv;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] dout_next;
  logic          dout_valid_next, wrap_next;

  assign step_edge = step && !step_q;
  assign adv       = (state == SHOW) && (step_edge || tick);

  tick_gen #(.N(PRESC)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (run && (state == SHOW)),
    .clr  (restart || adv),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    addr_next       = addr;
    dout_next       = dout;
    dout_valid_next = dout_valid;
    wrap_next       = 1'b0;
    if (restart) begin
      state_next = WAIT;
      addr_next  = '0;
    end else begin
      case (state)
        WAIT: state_next = CAP;
        CAP: begin
          dout_next       = rom_data;
          dout_valid_next = 1'b1;
          state_next      = (HALT_EN && (rom_data == HALT_CODE)) ? HALT : SHOW;
        end
        SHOW: begin
          if (adv) begin
            addr_next  = addr + AW'(1);
            wrap_next  = &addr;
            state_next = WAIT;
          end
        end
        HALT: ;
        default: state_next = WAIT;
      endcase
    end
  end

  // busy/halted are decoded from the next state so they stay flop outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b1;
      halted     <= 1'b0;
      wrap       <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      addr       <= addr_next;
      dout       <= dout_next;
      dout_valid <= dout_valid_next;
      busy       <= (state_next == WAIT) || (state_next == CAP);
      halted     <= (state_next == HALT);
      wrap       <= wrap_next;
      step_q     <= step;
    end
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// tb/tb_rom_sequencer.sv - randomized self-checking bench for rom_sequencer against a fetch-level model
module tb_rom_sequencer;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PRESC = 3;
  localparam int DEPTH = 1 << AW;
  localparam int TERM  = (1 << PRESC) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step = 1'b0;
  logic          run = 1'b0;
  logic          restart = 1'b0;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          dout_valid, busy, halted, wrap;

  logic [DW-1:0] rom [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;
  int wraps = 0;

  // Fetch-level reference: fetch_left counts remaining latency cycles after an address change.
  int m_addr, m_dout, m_dv, m_fetch, m_halt, m_cnt, m_stepq, m_wrap;

  rom_sequencer #(
    .AW(AW), .DW(DW), .PRESC(PRESC), .HALT_CODE(8'hFF), .HALT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .run(run), .restart(restart),
    .rom_data(rom_data), .addr(addr), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .halted(halted), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_dout = 0; m_dv = 0; m_fetch = 2;
    m_halt = 0; m_cnt = 0; m_stepq = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    bit edge_ev, tick_ev;
    edge_ev = step && (m_stepq == 0);
    m_stepq = step;
    m_wrap  = 0;
    if (restart) begin
      m_addr = 0; m_fetch = 2; m_halt = 0; m_cnt = 0;
    end else if (m_fetch == 2) begin
      m_fetch = 1;
    end else if (m_fetch == 1) begin
      m_dout  = rom[m_addr];
      m_dv    = 1;
      m_fetch = 0;
      m_cnt   = 0;
      if (rom[m_addr] == 8'hFF) m_halt = 1;
    end else if (!m_halt) begin
      tick_ev = run && (m_cnt == TERM);
      if (edge_ev || tick_ev) begin
        m_wrap  = (m_addr == DEPTH - 1);
        m_addr  = (m_addr + 1) % DEPTH;
        m_fetch = 2;
        m_cnt   = 0;
      end else begin
        m_cnt = run ? m_cnt + 1 : 0;
      end
    end
  endtask

  task automatic check_all();
    chk("addr", addr, m_addr);
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_dv);
    chk("busy", busy, m_fetch != 0);
    chk("halted", halted, m_halt);
    chk("wrap", wrap, m_wrap);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (wrap) wraps++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_step(input int gap);
    step = 1'b1;
    cycle();
    step = 1'b0;
    cycles(gap);
  endtask

  initial begin
    int a0;
    bit found;
    for (int i = 0; i < DEPTH; i++) rom[i] = DW'((i + 1) % DEPTH);

    // Reset and automatic first fetch
    @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b1;
    cycles(2);
    chk("boot_addr", addr, 0);
    chk("boot_dout", dout, 8'h01);
    chk("boot_valid", dout_valid, 1);
    chk("boot_busy", busy, 0);

    // Sixteen manual steps walk the full address range once
    wraps = 0;
    for (int i = 0; i < DEPTH; i++) pulse_step(9);
    chk("wrap_count", wraps, 1);
    chk("walk_end_addr", addr, 0);

    // Auto-run, then a step coinciding with a tick
    run = 1'b1;
    cycles(35);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_fetch == 0 && !m_halt && m_cnt == TERM) found = 1;
      else cycle();
    end
    chk("tick_found", found, 1);
    a0 = m_addr;
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("tick_step_once", addr, (a0 + 1) % DEPTH);
    cycles(12);
    run = 1'b0;

    // Halt on 0xFF at address 5, then restart
    rom[5] = 8'hFF;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    cycles(2);
    for (int i = 0; i < 5; i++) pulse_step(3);
    chk("halt_flag", halted, 1);
    chk("halt_dout", dout, 8'hFF);
    chk("halt_addr", addr, 5);
    run = 1'b1;
    for (int i = 0; i < 3; i++) pulse_step(4);
    cycles(30);
    chk("halt_hold_addr", addr, 5);
    run = 1'b0;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    chk("restart_addr", addr, 0);
    chk("restart_halted", halted, 0);
    chk("restart_keep_dout", dout, 8'hFF);
    cycles(2);
    chk("restart_dout", dout, rom[0]);
    rom[5] = 8'h06;

    // Back-to-back step edges: only the first is honoured
    cycles(3);
    a0 = m_addr;
    step = 1'b1; cycle();
    step = 1'b0; cycle();
    step = 1'b1; cycle();
    step = 1'b0; cycles(5);
    chk("fast_step_addr", addr, (a0 + 1) % DEPTH);

    // Asynchronous reset while in WAIT
    pulse_step(0);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_addr", addr, 0);
    chk("async_busy", busy, 1);
    chk("async_valid", dout_valid, 0);
    chk("async_dout", dout, 0);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    chk("post_reset_dout", dout, rom[0]);
    chk("post_reset_valid", dout_valid, 1);

    // Randomized mix; ROM contents only change together with a restart
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int i = 0; i < DEPTH; i++)
          rom[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : DW'($urandom_range(0, 254));
        restart = 1'b1;
      end else begin
        restart = 1'b0;
      end
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) run = ~run;
      cycle();
    end
    restart = 1'b0;
    step = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
